// File: rtl/axi_defines.sv
// Shared AXI4 burst/response encodings, the 4 KB page constant and the WRAP-length rule
// used by the burst address generator and its legality checker.
package axi_defines;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  localparam int AXI_4KB = 4096;

  // WRAP bursts must be 2, 4, 8 or 16 beats; len is beats minus one.
  function automatic logic axi_wrap_legal(input logic [31:0] len);
    return (len == 32'd1) || (len == 32'd3) || (len == 32'd7) || (len == 32'd15);
  endfunction

endpackage

// File: rtl/axi_burst_check.sv
// Combinational legality check for one AXI4 address-channel command.
module axi_burst_check
  import axi_defines::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [2:0]        size_i,
  input  burst_t            burst_i,
  output logic              illegal_o
);

  logic [31:0] bytes;
  logic [31:0] beats;
  logic [31:0] page_off;
  logic        misaligned;

  always_comb begin
    bytes      = 32'd1 << size_i;
    beats      = 32'(len_i) + 32'd1;
    // Offset of the aligned start address inside its 4 KB page.
    page_off   = 32'(addr_i[11:0]) & ~(bytes - 32'd1);
    misaligned = (addr_i & ADDR_W'(bytes - 32'd1)) != '0;

    illegal_o = 1'b0;
    if (bytes > 32'(DATA_W / 8))
      illegal_o = 1'b1;
    if (burst_i == BURST_RSVD)
      illegal_o = 1'b1;
    if ((burst_i == BURST_WRAP) && (!axi_wrap_legal(32'(len_i)) || misaligned))
      illegal_o = 1'b1;
    if ((burst_i == BURST_INCR) && ((page_off + beats * bytes) > 32'(AXI_4KB)))
      illegal_o = 1'b1;
  end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// AXI4 slave-side burst address generator: accepts one command, then emits one
// registered beat (address, index, last, response) per handshake.
module axi_burst_addr_gen
  import axi_defines::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [2:0]        cmd_size,
  input  burst_t            cmd_burst,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [ADDR_W-1:0] beat_addr,
  output logic [LEN_W-1:0]  beat_idx,
  output logic              beat_last,
  output resp_t             beat_resp,
  output logic              busy
);

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] bytes_q, bytes_d;
  logic [ADDR_W-1:0] wmask_q, wmask_d;
  logic [ADDR_W-1:0] next_addr;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  burst_t            burst_q, burst_d;
  resp_t             resp_q, resp_d;
  logic              illegal;

  axi_burst_check #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_check (
    .addr_i    (cmd_addr),
    .len_i     (cmd_len),
    .size_i    (cmd_size),
    .burst_i   (cmd_burst),
    .illegal_o (illegal)
  );

  assign cmd_ready  = (state_q == S_IDLE) && !rst;
  assign busy       = (state_q == S_BURST);
  assign beat_valid = valid_q;
  assign beat_addr  = addr_q;
  assign beat_idx   = idx_q;
  assign beat_last  = last_q;
  assign beat_resp  = resp_q;

  // Illegal bursts hold the start address; WRAP stays inside its W-aligned window.
  always_comb begin
    next_addr = addr_q;
    if (resp_q == RESP_OKAY) begin
      case (burst_q)
        BURST_INCR: next_addr = (addr_q & ~(bytes_q - ADDR_W'(1))) + bytes_q;
        BURST_WRAP: next_addr = (addr_q & ~wmask_q) | ((addr_q + bytes_q) & wmask_q);
        default:    next_addr = addr_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    last_d  = last_q;
    addr_d  = addr_q;
    bytes_d = bytes_q;
    wmask_d = wmask_q;
    idx_d   = idx_q;
    len_d   = len_q;
    burst_d = burst_q;
    resp_d  = resp_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = S_BURST;
          valid_d = 1'b1;
          addr_d  = cmd_addr;
          idx_d   = '0;
          last_d  = (cmd_len == '0);
          len_d   = cmd_len;
          burst_d = cmd_burst;
          resp_d  = illegal ? RESP_SLVERR : RESP_OKAY;
          bytes_d = ADDR_W'(1) << cmd_size;
          wmask_d = ((ADDR_W'(1) << cmd_size) * (ADDR_W'(cmd_len) + ADDR_W'(1))) - ADDR_W'(1);
        end
      end
      S_BURST: begin
        if (valid_q && beat_ready) begin
          if (last_q) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
          end else begin
            idx_d  = idx_q + LEN_W'(1);
            last_d = ((idx_q + LEN_W'(1)) == len_q);
            addr_d = next_addr;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      bytes_q <= '0;
      wmask_q <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      burst_q <= BURST_FIXED;
      resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      bytes_q <= bytes_d;
      wmask_q <= wmask_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      resp_q  <= resp_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Bench for axi_burst_addr_gen: directed vector table, hand-written corner sequences
// and randomized bursts checked against a closed-form reference model.
module tb_axi_burst_addr_gen;
  import axi_defines::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  burst_t      cmd_burst;
  logic        beat_valid;
  logic        beat_ready;
  logic [31:0] beat_addr;
  logic [7:0]  beat_idx;
  logic        beat_last;
  resp_t       beat_resp;
  logic        busy;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  axi_burst_addr_gen #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_size   (cmd_size),
    .cmd_burst  (cmd_burst),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_addr  (beat_addr),
    .beat_idx   (beat_idx),
    .beat_last  (beat_last),
    .beat_resp  (beat_resp),
    .busy       (busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  resp;
    logic [31:0] exp_addr [4];
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else
      passed++;
  endtask

  // Reference model: legality straight from the AXI rules, 32-bit data bus.
  function automatic bit ref_illegal(input logic [31:0] a, input int l, input int s, input int b);
    longint bb = longint'(1) << s;
    longint n  = longint'(l) + 1;
    longint aa = longint'(a);
    if (bb > 4) return 1'b1;
    if (b == 3) return 1'b1;
    if (b == 2 && !(n == 2 || n == 4 || n == 8 || n == 16)) return 1'b1;
    if (b == 2 && (aa % bb) != 0) return 1'b1;
    if (b == 1 && ((aa % 4096) / bb * bb + n * bb > 4096)) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: address of beat k computed directly, not iteratively.
  function automatic logic [31:0] ref_addr(input logic [31:0] a, input int l, input int s,
                                           input int b, input int k);
    longint bb = longint'(1) << s;
    longint aa = longint'(a);
    longint w, base;
    if (b == 1) begin
      if (k == 0) return a;
      return 32'((aa / bb * bb + longint'(k) * bb) % (longint'(1) << 32));
    end
    if (b == 2) begin
      w    = bb * (longint'(l) + 1);
      base = aa / w * w;
      return 32'(base + ((aa - base + longint'(k) * bb) % w));
    end
    return a;
  endfunction

  // Issues one command and consumes its beats; expectations come from the table
  // (use_tab) or from the reference model.
  task automatic do_burst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b, input bit use_tab, input logic [31:0] tab[4],
                          input logic [1:0] tab_resp, input int stall_beat, input int stall_cyc,
                          input bit rnd_stall);
    int budget;
    bit ill;
    logic [31:0] ea;
    logic [1:0]  er;
    int st;
    budget = 0;
    while (!cmd_ready && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_size  = s;
    cmd_burst = burst_t'(b);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    ill = ref_illegal(a, int'(l), int'(s), int'(b));
    for (int n = 0; n <= int'(l); n++) begin
      if (use_tab) begin
        ea = tab[n];
        er = tab_resp;
      end else begin
        ea = ill ? a : ref_addr(a, int'(l), int'(s), int'(b), n);
        er = ill ? 2'b10 : 2'b00;
      end
      chk("beat_valid", 64'(beat_valid), 64'd1);
      chk("beat_addr",  64'(beat_addr),  64'(ea));
      chk("beat_idx",   64'(beat_idx),   64'(n));
      chk("beat_last",  64'(beat_last),  64'(n == int'(l)));
      chk("beat_resp",  64'(beat_resp),  64'(er));
      st = 0;
      if (n == stall_beat) st = stall_cyc;
      else if (rnd_stall && ($urandom % 4 == 0)) st = 1 + int'($urandom % 2);
      if (st > 0) begin
        beat_ready = 1'b0;
        for (int c = 0; c < st; c++) begin
          @(posedge clk); #1;
          chk("stall_valid", 64'(beat_valid), 64'd1);
          chk("stall_addr",  64'(beat_addr),  64'(ea));
          chk("stall_idx",   64'(beat_idx),   64'(n));
        end
        beat_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("end_valid", 64'(beat_valid), 64'd0);
    chk("end_busy",  64'(busy),       64'd0);
    chk("end_ready", 64'(cmd_ready),  64'd1);
  endtask

  initial begin
    logic [31:0] none [4];
    logic [31:0] a;
    logic [7:0]  l;
    logic [2:0]  s;
    logic [1:0]  b;
    int budget;
    none = '{32'h0, 32'h0, 32'h0, 32'h0};

    vecs[0] = '{32'h1000, 8'd3, 3'd2, 2'b01, 2'b00, '{32'h1000, 32'h1004, 32'h1008, 32'h100C}};
    vecs[1] = '{32'h1034, 8'd3, 3'd2, 2'b10, 2'b00, '{32'h1034, 32'h1038, 32'h103C, 32'h1030}};
    vecs[2] = '{32'h1034, 8'd2, 3'd2, 2'b10, 2'b10, '{32'h1034, 32'h1034, 32'h1034, 32'h0}};
    vecs[3] = '{32'h2000, 8'd2, 3'd2, 2'b00, 2'b00, '{32'h2000, 32'h2000, 32'h2000, 32'h0}};
    vecs[4] = '{32'h1003, 8'd1, 3'd2, 2'b01, 2'b00, '{32'h1003, 32'h1004, 32'h0, 32'h0}};
    vecs[5] = '{32'h1FF8, 8'd3, 3'd2, 2'b01, 2'b10, '{32'h1FF8, 32'h1FF8, 32'h1FF8, 32'h1FF8}};
    vecs[6] = '{32'h1000, 8'd1, 3'd3, 2'b01, 2'b10, '{32'h1000, 32'h1000, 32'h0, 32'h0}};
    vecs[7] = '{32'h3000, 8'd1, 3'd2, 2'b11, 2'b10, '{32'h3000, 32'h3000, 32'h0, 32'h0}};
    vecs[8] = '{32'h0500, 8'd0, 3'd2, 2'b01, 2'b00, '{32'h0500, 32'h0, 32'h0, 32'h0}};
    vecs[9] = '{32'h1002, 8'd3, 3'd2, 2'b10, 2'b10, '{32'h1002, 32'h1002, 32'h1002, 32'h1002}};

    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_len    = '0;
    cmd_size   = '0;
    cmd_burst  = BURST_FIXED;
    beat_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready),  64'd0);
    chk("rst_valid",     64'(beat_valid), 64'd0);
    chk("rst_busy",      64'(busy),       64'd0);
    chk("rst_addr",      64'(beat_addr),  64'd0);
    chk("rst_idx",       64'(beat_idx),   64'd0);
    chk("rst_last",      64'(beat_last),  64'd0);
    chk("rst_resp",      64'(beat_resp),  64'd0);
    rst = 1'b0;
    #1;
    chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 10; i++)
      do_burst(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, 1'b1,
               vecs[i].exp_addr, vecs[i].resp, -1, 0, 1'b0);

    // 8-beat INCR with a 3-cycle stall on beat 1.
    do_burst(32'h0000_0100, 8'd7, 3'd2, 2'b01, 1'b0, none, 2'b00, 1, 3, 1'b0);

    // cmd_valid held high through a burst is only taken once the burst is done.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = 32'h100; cmd_len = 8'd1; cmd_size = 3'd2; cmd_burst = BURST_INCR;
    @(posedge clk); #1;
    cmd_addr = 32'h40; cmd_len = 8'd0;
    chk("hold_b0_addr",  64'(beat_addr), 64'h100);
    chk("hold_b0_ready", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1;
    chk("hold_b1_addr",  64'(beat_addr), 64'h104);
    chk("hold_b1_last",  64'(beat_last), 64'd1);
    @(posedge clk); #1;
    chk("hold_gap_valid", 64'(beat_valid), 64'd0);
    chk("hold_gap_ready", 64'(cmd_ready),  64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("hold_next_valid", 64'(beat_valid), 64'd1);
    chk("hold_next_addr",  64'(beat_addr),  64'h40);
    chk("hold_next_idx",   64'(beat_idx),   64'd0);
    chk("hold_next_last",  64'(beat_last),  64'd1);
    @(posedge clk); #1;
    chk("hold_done_valid", 64'(beat_valid), 64'd0);

    // Reset in the middle of a 4-beat burst.
    budget = 0;
    while (!cmd_ready && budget < 20) begin @(posedge clk); #1; budget++; end
    cmd_valid = 1'b1; cmd_addr = 32'h800; cmd_len = 8'd3; cmd_size = 3'd2; cmd_burst = BURST_INCR;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_idx",  64'(beat_idx),  64'd2);
    chk("mid_addr", 64'(beat_addr), 64'h808);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 64'(beat_valid), 64'd0);
    chk("mid_rst_busy",  64'(busy),       64'd0);
    chk("mid_rst_ready", 64'(cmd_ready),  64'd0);
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", 64'(cmd_ready), 64'd1);
    do_burst(vecs[0].addr, vecs[0].len, vecs[0].size, vecs[0].burst, 1'b1,
             vecs[0].exp_addr, vecs[0].resp, -1, 0, 1'b0);

    // Randomized bursts against the reference model.
    for (int r = 0; r < 60; r++) begin
      b = 2'($urandom % 4);
      s = 3'($urandom % 4);
      if (b == 2'b10) begin
        case ($urandom % 5)
          0: l = 8'd1;
          1: l = 8'd3;
          2: l = 8'd7;
          3: l = 8'd15;
          default: l = 8'd2;
        endcase
      end else begin
        l = 8'($urandom % 16);
      end
      if ($urandom % 2 == 0)
        a = {20'($urandom), 12'(4096 - int'($urandom % 72))};
      else
        a = $urandom;
      if (b == 2'b10 && ($urandom % 4 != 0))
        a = a & ~((32'd1 << s) - 32'd1);
      do_burst(a, l, s, b, 1'b0, none, 2'b00, -1, 0, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
